// File: rtl/spawn_dispatcher.sv
// ============================================================================
// spawn_dispatcher
//
// Receiving end of the processor SPAWN handshake. Spawn requests from N
// processors (two-phase toggle on TRIGGER_SPAWN) are accepted round-robin,
// one per cycle, into an address FIFO. Queued addresses are issued, one per
// cycle, to the lowest-numbered idle processor as a one-cycle START pulse.
//
// Optional feature macro: SPAWN_DISPATCH_BOOT_EN
//   When defined, BOOT_ADDR is pushed into the FIFO on the first cycle after
//   reset deasserts (no ack toggled), so processor 0 boots from it.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-high reset, clears all state
//   TRIGGER_SPAWN  [N]    per-processor request toggle
//   SPAWN_ADDR     [8N]   per-processor requested address (bits 8i+7:8i)
//   RUN            [N]    per-processor running flag
//   DISP_ACK       [N]    per-processor ack phase (matches trigger when done)
//   START          [N]    one-cycle start pulse per processor
//   START_ADDR     [8N]   per-processor start address, held after the pulse
//   FIFO_COUNT     number of queued addresses
//   BUSY           any queued entry, pending request, start in flight or RUN
// ============================================================================
module spawn_dispatcher #(
    parameter int         N         = 4,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] BOOT_ADDR = 8'h00
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N-1:0]                 TRIGGER_SPAWN,
    input  logic [8*N-1:0]               SPAWN_ADDR,
    input  logic [N-1:0]                 RUN,
    output logic [N-1:0]                 DISP_ACK,
    output logic [N-1:0]                 START,
    output logic [8*N-1:0]               START_ADDR,
    output logic [$clog2(DEPTH+1)-1:0]   FIFO_COUNT,
    output logic                         BUSY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     start_q, start_d;
    logic [N-1:0]     inflight_q, inflight_d;
    logic [7:0]       start_addr_q [N];
    logic             busy_q, busy_d;

    // Per-processor views of the packed address buses
    logic [7:0]       spawn_addr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign spawn_addr[gi]          = SPAWN_ADDR[8*gi +: 8];
            assign START_ADDR[8*gi +: 8]   = start_addr_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Boot push (optional)
    // ------------------------------------------------------------------
    logic boot_push;

`ifdef SPAWN_DISPATCH_BOOT_EN
    logic boot_done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            boot_done_q <= 1'b0;
        end else begin
            boot_done_q <= 1'b1;
        end
    end

    // High exactly on the first cycle after reset release.
    assign boot_push = !boot_done_q;
`else
    assign boot_push = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Accept engine: round-robin search starting at rr_q
    // ------------------------------------------------------------------
    logic [N-1:0]     pending;
    logic             acc_found;
    logic [IDX_W-1:0] acc_idx;
    int               acc_best;
    int               acc_dist;

    assign pending = TRIGGER_SPAWN ^ ack_q;

    // Pick the pending requester with the smallest circular distance from
    // the round-robin pointer.
    always_comb begin
        acc_found = 1'b0;
        acc_idx   = '0;
        acc_best  = N;
        acc_dist  = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(rr_q)) begin
                acc_dist = i - int'(rr_q);
            end else begin
                acc_dist = i + N - int'(rr_q);
            end
            if (pending[i] && (acc_dist < acc_best)) begin
                acc_found = 1'b1;
                acc_idx   = IDX_W'(i);
                acc_best  = acc_dist;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue engine: lowest-numbered eligible processor
    // ------------------------------------------------------------------
    logic [N-1:0]     eligible;
    logic             iss_found;
    logic [IDX_W-1:0] iss_idx;

    // The in-flight mask covers the gap between START and RUN rising.
    assign eligible = ~RUN & ~start_q & ~inflight_q;

    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(j);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic       acc_take;
    logic       push;
    logic       pop;
    logic [7:0] push_data;

    always_comb begin
        // Full test uses the pre-pop count; boot push owns its cycle.
        acc_take  = acc_found && !boot_push && (count_q < CNT_W'(DEPTH));
        push      = boot_push || acc_take;
        // No bypass: only entries already in the FIFO can be popped.
        pop       = iss_found && (count_q != '0);
        push_data = boot_push ? BOOT_ADDR : spawn_addr[acc_idx];

        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        ack_d = ack_q;
        rr_d  = rr_q;
        if (acc_take) begin
            ack_d[acc_idx] = TRIGGER_SPAWN[acc_idx];
            rr_d = (acc_idx == IDX_W'(N - 1)) ? '0 : (acc_idx + IDX_W'(1));
        end

        start_d    = '0;
        inflight_d = inflight_q & ~RUN;
        if (pop) begin
            start_d[iss_idx]    = 1'b1;
            inflight_d[iss_idx] = 1'b1;
        end

        busy_d = (count_d != '0) || (|(TRIGGER_SPAWN ^ ack_d)) ||
                 (|inflight_d) || (|RUN);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_q       <= '0;
            ack_q      <= '0;
            start_q    <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            for (int k = 0; k < N; k++) begin
                start_addr_q[k] <= 8'h00;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            ack_q      <= ack_d;
            start_q    <= start_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            if (pop) begin
                start_addr_q[iss_idx] <= fifo_mem[rd_ptr_q];
            end
        end
    end

    // FIFO storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    assign DISP_ACK   = ack_q;
    assign START      = start_q;
    assign FIFO_COUNT = count_q;
    assign BUSY       = busy_q;

endmodule

// File: doc/spawn_dispatcher.md
# spawn_dispatcher

- Receiving end of the processor SPAWN handshake: collects spawn requests from `N` processors, queues the requested start addresses, and starts idle processors at those addresses.
- Requester side uses two-phase toggle signalling: each processor toggles `TRIGGER_SPAWN` with `SPAWN_ADDR` valid, and waits for `DISP_ACK` to match before its next spawn.
- The block sits between the processor array and the cluster top level; it owns every processor's `START`/`START_ADDR` and `DISP_ACK`.

## Interface
Parameters:
- `N`, 4 — number of processors served, 1..8.
- `DEPTH`, 8 — address FIFO entries; power of two, ≥2.
- `BOOT_ADDR`, 8'h00 — address of the boot task (see Configuration).

Ports:
- `clock`  in  1  — sole clock, rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `TRIGGER_SPAWN`  in  N  — bit i toggles when processor i requests a spawn.
- `SPAWN_ADDR`  in  8·N  — bits [8i+7:8i] are processor i's requested address, stable while its request is pending.
- `RUN`  in  N  — bit i high while processor i executes.
- `DISP_ACK`  out  N  — bit i is set equal to `TRIGGER_SPAWN[i]` on acceptance.
- `START`  out  N  — one-cycle start pulse per processor.
- `START_ADDR`  out  8·N  — per-processor start address, valid while `START[i]` is high and held afterwards.
- `FIFO_COUNT`  out  $clog2(DEPTH+1)  — queued addresses.
- `BUSY`  out  1  — high when there is any queued entry, pending request, start in flight, or `RUN` bit set.

## Operation
- Reset values: `DISP_ACK` = 0, `START` = 0, `START_ADDR` = 0, `FIFO_COUNT` = 0, `BUSY` = 0; round-robin pointer = 0; in-flight mask = 0.
- Request i is pending iff `TRIGGER_SPAWN[i] != DISP_ACK[i]`.
- **Accept engine**, at most one request per cycle:
  - Runs only if `FIFO_COUNT < DEPTH`.
  - Search starts at the round-robin pointer. The first pending i has `SPAWN_ADDR[i]` written at the tail and `DISP_ACK[i] <= TRIGGER_SPAWN[i]`.
  - The pointer then moves to i+1 mod N.
  - FIFO full: no accept, no ack; requesters stall.
- **Issue engine**, at most one start per cycle:
  - Processor j is eligible iff `RUN[j]`=0, `START[j]`=0 and in-flight bit j=0.
  - If the FIFO is non-empty and an eligible j exists, take the lowest such j: head popped, `START_ADDR[j]` <= head, `START[j]` <= 1 for one cycle, in-flight bit j set.
  - In-flight bit j clears on the first cycle `RUN[j]` is sampled high. This covers the one-cycle lag before the processor raises `RUN`.
- Simultaneous push and pop: both occur and the count is unchanged.
- Full check uses the pre-pop count, so a full FIFO refuses the push even when a pop happens that cycle.
- The FIFO has no bypass: an address accepted in cycle k is issued at the earliest in cycle k+1.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Reset mid-operation: the queue is discarded and acks return to 0. Processors must be reset together with this block, otherwise toggle phases desync.

## Timing
- Pending at edge k → `DISP_ACK` toggles and the entry is written at edge k+1.
- `START[j]` rises at edge k+2 at the earliest (FIFO previously empty, j idle) and falls at k+3.
- Throughput: one accept and one issue per cycle sustained.
- Starvation bound: a pending request is accepted within N accept-eligible cycles.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- Macro `SPAWN_DISPATCH_BOOT_EN`.
- Defined: on the first cycle after reset deasserts, the block pushes `BOOT_ADDR` into the FIFO as if accepted (no ack toggled). `BUSY` and `FIFO_COUNT` reflect it, and processor 0 starts at `BOOT_ADDR` at edge 2 after reset release.
- Undefined: the FIFO is empty after reset and nothing starts until an external spawn request arrives.

## Test plan
- Boot: `SPAWN_DISPATCH_BOOT_EN` defined, `BOOT_ADDR`=8'h10, all `RUN`=0 → `START`=4'b0001 for one cycle at edge 2 with `START_ADDR[0]`=8'h10. With the macro undefined, `START` stays 0.
- Single spawn: processor 0 running and toggles `TRIGGER_SPAWN[0]` with address 8'h2A, processors 1..3 idle →
  - `DISP_ACK[0]`=1 one edge later;
  - `START[1]` pulses one edge after that with `START_ADDR[1]`=8'h2A;
  - no second start to processor 1 while `RUN[1]` is still low.
- Round-robin: all four toggle in the same cycle with addresses 8'h01..8'h04 and pointer at 2 → acks in order 2,3,0,1 on consecutive edges; FIFO order 03,04,01,02.
- Full: `DEPTH`=8, all `RUN`=1, nine requests → `FIFO_COUNT`=8 and the ninth stays unacked. Dropping `RUN[3]` → `START[3]` with the oldest address, then the ninth is accepted the following cycle.
- Simultaneous push/pop at count 3 → count stays 3, and the order is preserved across pointer wrap.
- Reset asserted mid-stream with count 5 → all outputs return to zero asynchronously; no `START` after release (macro undefined).
